// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core: opcodes, FSM states,
// ALU/immediate/mux encodings, plus the immediate extender and ALU as pure functions.
package mc_pkg;

    localparam int XW = 32;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, HALT
    } state_e;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_ctl_e;
    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;
    typedef enum logic [1:0] {PC_PLUS4, PC_ALUOUT, PC_ALU} pc_src_e;
    typedef enum logic [1:0] {WB_ALUOUT, WB_DATA, WB_LINK} wb_src_e;

    function automatic logic [XW-1:0] imm_ext(input logic [31:7] ins, input logic [1:0] sel);
        case (sel)
            IMM_I:   imm_ext = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm_ext = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm_ext = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            default: imm_ext = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [XW-1:0] alu_fn(input logic [XW-1:0] a, input logic [XW-1:0] b,
                                             input logic [2:0] ctl);
        case (ctl)
            ALU_SUB: alu_fn = a - b;
            ALU_AND: alu_fn = a & b;
            ALU_OR:  alu_fn = a | b;
            ALU_SLT: alu_fn = {{(XW-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_fn = a + b;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller.sv
// Main control FSM: sequences fetch/decode/execute and decodes opcode/funct into
// datapath enables and mux selects; memory states hold until mem_ready.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    input  logic       alu_zero,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_sel,
    output logic       ir_we,
    output logic       ab_we,
    output logic       aluout_we,
    output logic       data_we,
    output logic       rf_we,
    output logic       pc_we,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [2:0] alu_ctl,
    output logic [1:0] imm_src,
    output logic [1:0] pc_src,
    output logic [1:0] wb_src,
    output logic       halted,
    output logic       retire
);

    state_e state_q, state_d;
    logic [2:0] f3_ctl;
    logic       f3_ok, r_ok, mem_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        f3_ctl = ALU_ADD;
        case (funct3)
            3'b010:  f3_ctl = ALU_SLT;
            3'b110:  f3_ctl = ALU_OR;
            3'b111:  f3_ctl = ALU_AND;
            default: f3_ctl = ALU_ADD;
        endcase
        f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b110) || (funct3 == 3'b111);
        r_ok   = ((funct7 == 7'b0000000) && f3_ok) || ((funct7 == 7'b0100000) && (funct3 == 3'b000));
        mem_ok = ((op == OP_LW) || (op == OP_SW)) && (funct3 == 3'b010);
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        adr_sel   = 1'b0;
        ir_we     = 1'b0;
        ab_we     = 1'b0;
        aluout_we = 1'b0;
        data_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        alu_ctl   = ALU_ADD;
        imm_src   = IMM_I;
        pc_src    = PC_PLUS4;
        wb_src    = WB_ALUOUT;
        halted    = 1'b0;
        retire    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Branch target is precomputed here so BEQ needs no extra cycle.
                ab_we     = 1'b1;
                aluout_we = 1'b1;
                alu_a_sel = 1'b1;
                alu_b_sel = 1'b1;
                imm_src   = IMM_B;
                if (mem_ok)                                     state_d = MEMADR;
                else if ((op == OP_R) && r_ok)                  state_d = EXECR;
                else if ((op == OP_I) && f3_ok)                 state_d = EXECI;
                else if ((op == OP_BEQ) && (funct3 == 3'b000))  state_d = BEQ;
                else if (op == OP_JAL)                          state_d = JAL;
                else                                            state_d = HALT;
            end
            MEMADR: begin
                aluout_we = 1'b1;
                alu_b_sel = 1'b1;
                imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
                state_d   = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_sel = 1'b1;
                if (mem_ready) begin
                    data_we = 1'b1;
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                rf_we   = 1'b1;
                wb_src  = WB_DATA;
                retire  = 1'b1;
                state_d = FETCH;
            end
            MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_sel = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXECR: begin
                aluout_we = 1'b1;
                alu_ctl   = ((funct3 == 3'b000) && funct7[5]) ? ALU_SUB : f3_ctl;
                state_d   = ALUWB;
            end
            EXECI: begin
                aluout_we = 1'b1;
                alu_b_sel = 1'b1;
                alu_ctl   = f3_ctl;
                state_d   = ALUWB;
            end
            ALUWB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            BEQ: begin
                alu_ctl = ALU_SUB;
                pc_we   = alu_zero;
                pc_src  = PC_ALUOUT;
                retire  = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                alu_a_sel = 1'b1;
                alu_b_sel = 1'b1;
                imm_src   = IMM_J;
                pc_we     = 1'b1;
                pc_src    = PC_ALU;
                rf_we     = 1'b1;
                wb_src    = WB_LINK;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_d = HALT;
        endcase
    end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle RV32I-subset core: datapath registers, register file, ALU and extender
// around mc_controller; one shared memory port, stalls while mem_ready is low.
module mc_core
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREGS    = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            halted,
    output logic            retire
);

    localparam int RW = $clog2(NREGS);

    logic [XLEN-1:0] pc_q, pc_d, oldpc_q, oldpc_d, instr_q, instr_d, data_q, data_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d;
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];

    logic            ctrl_req, adr_sel, ir_we, ab_we, aluout_we, data_we, rf_we, pc_we;
    logic            alu_a_sel, alu_b_sel, alu_zero;
    logic [2:0]      alu_ctl;
    logic [1:0]      imm_src, pc_src, wb_src;
    logic [RW-1:0]   rs1_i, rs2_i, rd_i;
    logic [XLEN-1:0] rd1, rd2, imm, alu_a, alu_b, alu_y, wb_data, adr;

    mc_controller u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .op        (instr_q[6:0]),
        .funct3    (instr_q[14:12]),
        .funct7    (instr_q[31:25]),
        .mem_ready (mem_ready),
        .alu_zero  (alu_zero),
        .mem_req   (ctrl_req),
        .mem_we    (mem_we),
        .adr_sel   (adr_sel),
        .ir_we     (ir_we),
        .ab_we     (ab_we),
        .aluout_we (aluout_we),
        .data_we   (data_we),
        .rf_we     (rf_we),
        .pc_we     (pc_we),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .alu_ctl   (alu_ctl),
        .imm_src   (imm_src),
        .pc_src    (pc_src),
        .wb_src    (wb_src),
        .halted    (halted),
        .retire    (retire)
    );

    // Reset drops the request combinationally so an in-flight access is abandoned at once.
    assign mem_req   = ctrl_req & ~reset;
    assign adr       = adr_sel ? aluout_q : pc_q;
    assign mem_addr  = {adr[XLEN-1:2], 2'b00};
    assign mem_wdata = b_q;

    always_comb begin
        rs1_i    = instr_q[15 +: RW];
        rs2_i    = instr_q[20 +: RW];
        rd_i     = instr_q[7 +: RW];
        rd1      = (rs1_i == '0) ? '0 : rf_q[rs1_i];
        rd2      = (rs2_i == '0) ? '0 : rf_q[rs2_i];
        imm      = imm_ext(instr_q[31:7], imm_src);
        alu_a    = alu_a_sel ? oldpc_q : a_q;
        alu_b    = alu_b_sel ? imm : b_q;
        alu_y    = alu_fn(alu_a, alu_b, alu_ctl);
        alu_zero = (alu_y == '0);

        pc_d = pc_q;
        if (pc_we) begin
            case (pc_src)
                PC_ALUOUT: pc_d = aluout_q;
                PC_ALU:    pc_d = alu_y;
                default:   pc_d = pc_q + XLEN'(4);
            endcase
        end
        oldpc_d  = ir_we ? pc_q : oldpc_q;
        instr_d  = ir_we ? mem_rdata : instr_q;
        data_d   = data_we ? mem_rdata : data_q;
        a_d      = ab_we ? rd1 : a_q;
        b_d      = ab_we ? rd2 : b_q;
        aluout_d = aluout_we ? alu_y : aluout_q;

        case (wb_src)
            WB_DATA: wb_data = data_q;
            WB_LINK: wb_data = oldpc_q + XLEN'(4);
            default: wb_data = aluout_q;
        endcase
        rf_d = rf_q;
        if (rf_we && (rd_i != '0)) rf_d[rd_i] = wb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            oldpc_q  <= '0;
            instr_q  <= '0;
            data_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            oldpc_q  <= oldpc_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

endmodule
